bcd_updown_timer: RTL
=====================

Name: bcd_updown_timer

Overview:
- Parametrised multi-digit BCD timer that counts up from 0 to a loaded target, or down from the target to 0.
- Successor to the two-digit seconds timer.
- Adds:
  - configurable digit count;
  - built-in clock prescaler;
  - up/down mode;
  - pause/resume;
  - auto-reload;
  - a one-cycle expiry pulse;
  - rejection of non-BCD load values.
- Sits between the board-level control logic and the seven-segment/digit display driver.

Parameters:
- NUM_DIGITS, 4: number of BCD digits; the count range is 0 to 10^NUM_DIGITS-1.
- PRESCALE, 1: Clock cycles per count step. Must be 1 or greater; 1 means step every cycle.
- PRE_W, 1 or greater: prescaler width, equal to clog2(PRESCALE) and at least 1.

Ports:
- Clock, in, 1: system clock, rising edge.
- Reset, in, 1: synchronous, active-high.
- Load, in, 1: load Timer_In_Value as the target.
- Timer_In_Value, in, 4*NUM_DIGITS: BCD target. Digit 0 occupies [3:0].
- Start, in, 1: start from IDLE/DONE, or resume from PAUSE.
- Stop, in, 1: pause while RUN.
- Mode_Down, in, 1: 0 = count up to target; 1 = count down to 0. Latched at Load and at Start from IDLE/DONE.
- Auto_Reload, in, 1: 1 = restart automatically at terminal. Sampled live.
- Digits, out, 4*NUM_DIGITS: current BCD count, registered.
- Time_Out, out, 1: high while in DONE.
- Expire_Pulse, out, 1: one-cycle pulse each time the terminal value is reached.
- Running, out, 1: high while in RUN.
- Load_Error, out, 1: one-cycle pulse when a Load is rejected.

Behaviour:
- All outputs are registered.
- Reset values: Digits=0, Time_Out=0, Expire_Pulse=0, Running=0, Load_Error=0.
- Internal reset state: Time_Reg=0, mode latch=0, prescaler=0, state=IDLE.
- States: IDLE, RUN, PAUSE, DONE.
- Terminal value is Time_Reg when counting up, and 0 when counting down.
- Start value is 0 when counting up, and Time_Reg when counting down.
- Priority within one cycle: Reset > Load > Stop > Start.
- Load in IDLE or DONE:
  - If any nibble of Timer_In_Value is greater than 9, Load_Error=1 for the next cycle and nothing changes.
  - Otherwise: Time_Reg <= value, mode latch <= Mode_Down, Digits <= start value, state <= IDLE.
- Load in RUN or PAUSE: ignored, and Load_Error pulses for one cycle.
- Start in IDLE or DONE:
  - Mode latch <= Mode_Down.
  - Digits <= start value for the new mode.
  - Prescaler <= 0.
  - If start value equals terminal (for example, target 0): state <= DONE and Expire_Pulse=1 on the next cycle.
  - Otherwise: state <= RUN.
- RUN:
  - The prescaler increments every cycle and wraps at PRESCALE-1.
  - tick = (prescaler == PRESCALE-1).
- On a tick in RUN:
  - If Digits == terminal (only possible with auto-reload), Digits <= start value.
  - Otherwise Digits steps by +/-1 in BCD, with carry or borrow rippling digit to digit within the same cycle (9+1 gives 0 with carry; 0-1 gives 9 with borrow).
  - If the new value equals terminal: Expire_Pulse=1 on the next cycle, and state <= DONE unless Auto_Reload=1, in which case the block stays in RUN.
- First Digits change occurs on the PRESCALE-th rising edge after the edge that sampled Start.
  - With auto-reload, the terminal value is displayed for exactly one period (PRESCALE cycles) before the reload.
- Stop in RUN: state <= PAUSE. Digits and prescaler are held.
- Start in PAUSE: state <= RUN, resuming with the prescaler continuing from its held value.
- Start in RUN: ignored. Stop in IDLE, PAUSE or DONE: ignored.
- DONE: Digits held, Time_Out=1. Leaves DONE only via Start, Load or Reset.
- No wrap-around past 10^NUM_DIGITS-1 or below 0: the terminal value is always reached first.
- Reset mid-run: all outputs and state return to their reset values on the next edge. Time_Reg is cleared.
- Mode_Down and Auto_Reload changes in RUN:
  - Mode_Down: ignored until the next latch point.
  - Auto_Reload: affects the next terminal event.

Decomposition:
- Package bcd_timer_pkg:
  - state enum {IDLE, RUN, PAUSE, DONE};
  - BCD_W=4;
  - BCD_MAX=4'd9;
  - function is_bcd(nibble).
- Sub-module bcd_digit_updown, instantiated NUM_DIGITS times in a generate loop:
  - Inputs: en, down, load, load_val. Load has priority over en.
  - Outputs: q, and a combinational carry_out (up) or borrow_out (down).
  - Each digit's en = tick AND carry/borrow out of all lower digits.

Test Plan:
- NUM_DIGITS=2, PRESCALE=1, up mode: Load 8'h12, Start → Digits steps 00, 01 … 12, one cycle apart. Expire_Pulse high exactly one cycle. Time_Out=1 and Digits holds 12.
- Down mode: Load 8'h10, Start → 10, 09, 08 … 00, with borrow across the digit boundary. Then DONE.
- PRESCALE=3, Auto_Reload=1, up, target 8'h02 → Digits sequence 00, 01, 02, 00, 01, 02, each value held 3 cycles. Expire_Pulse once per pass. Running stays 1.
- Stop asserted at Digits=05 for 7 cycles, then Start → Digits holds 05 throughout the pause. The remaining step spacing is unchanged.
- Load 8'h1A in IDLE → Load_Error one cycle, Time_Reg unchanged. Load during RUN → Load_Error one cycle, count unaffected. Load and Start in the same cycle → load only, state IDLE.
- Target 8'h00, up mode, Start → DONE next cycle with one Expire_Pulse. Reset asserted mid-RUN → Digits=00, Running=0, state IDLE the next cycle.

Source files
------------

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the multi-digit BCD up/down timer.
// Imported by the digit cell and the timer top.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(
    input logic [BCD_W-1:0] nibble
  );
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One BCD digit that can step up or down.
// co flags a carry (up) or borrow (down) out of this digit.
module bcd_digit_updown
  import bcd_timer_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] q,
  output logic [BCD_W-1:0] d_next,
  output logic             co
);

  always_comb begin
    d_next = q;
    co     = 1'b0;
    if (down) begin
      co     = (q == '0);
      d_next = co ? BCD_MAX : q - BCD_W'(1);
    end else begin
      co     = (q == BCD_MAX);
      d_next = co ? '0 : q + BCD_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (en)
      q <= d_next;
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// Multi-digit BCD timer: counts 0->target or target->0,
// with prescaler, pause/resume, auto-reload and load checks.
module bcd_updown_timer
  import bcd_timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1,
  parameter int PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Load,
  input  logic [BCD_W*NUM_DIGITS-1:0] Timer_In_Value,
  input  logic                        Start,
  input  logic                        Stop,
  input  logic                        Mode_Down,
  input  logic                        Auto_Reload,
  output logic [BCD_W*NUM_DIGITS-1:0] Digits,
  output logic                        Time_Out,
  output logic                        Expire_Pulse,
  output logic                        Running,
  output logic                        Load_Error
);

  localparam int W = BCD_W * NUM_DIGITS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t           r_state, w_nstate;
  logic [W-1:0]     r_time;
  logic             r_mode;
  logic [PRE_W-1:0] r_pre;
  logic             r_expire, r_lerr, r_running, r_time_out;

  logic [W-1:0] w_digits, w_nxt, w_step;
  logic [W-1:0] w_term, w_start, w_dval;
  logic [NUM_DIGITS-1:0] w_en, w_co;
  logic w_dload, w_run, w_tick, w_at_term, w_bad;
  logic w_expire, w_lerr, w_tload, w_mload, w_mval, w_pclr;
  logic w_unused_co;

  assign w_term    = r_mode ? '0 : r_time;
  assign w_start   = r_mode ? r_time : '0;
  assign w_tick    = (r_pre == PRE_LAST);
  assign w_at_term = (w_digits == w_term);

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!is_bcd(Timer_In_Value[i*BCD_W +: BCD_W]))
        w_bad = 1'b1;
  end

  // Counting carries on through a rejected Load while in RUN
  always_comb begin
    w_nstate = r_state;
    w_dload  = 1'b0;
    w_dval   = '0;
    w_expire = 1'b0;
    w_lerr   = 1'b0;
    w_run    = 1'b0;
    w_tload  = 1'b0;
    w_mload  = 1'b0;
    w_mval   = r_mode;
    w_pclr   = 1'b0;
    if (Load) begin
      if (r_state == IDLE || r_state == DONE) begin
        if (w_bad) begin
          w_lerr = 1'b1;
        end else begin
          w_tload  = 1'b1;
          w_mload  = 1'b1;
          w_mval   = Mode_Down;
          w_dload  = 1'b1;
          w_dval   = Mode_Down ? Timer_In_Value : '0;
          w_nstate = IDLE;
        end
      end else begin
        w_lerr = 1'b1;
        w_run  = (r_state == RUN);
      end
    end else if (Stop && r_state == RUN) begin
      w_nstate = PAUSE;
    end else if (Start &&
                 (r_state == IDLE || r_state == DONE)) begin
      w_mload = 1'b1;
      w_mval  = Mode_Down;
      w_dload = 1'b1;
      w_dval  = Mode_Down ? r_time : '0;
      w_pclr  = 1'b1;
      if (r_time == '0) begin
        w_nstate = DONE;
        w_expire = 1'b1;
      end else begin
        w_nstate = RUN;
      end
    end else if (Start && r_state == PAUSE) begin
      w_nstate = RUN;
    end else if (r_state == RUN) begin
      w_run = 1'b1;
    end

    if (w_run && w_tick) begin
      if (w_at_term) begin
        w_dload = 1'b1;
        w_dval  = w_start;
      end else if (w_step == w_term) begin
        w_expire = 1'b1;
        if (!Auto_Reload)
          w_nstate = DONE;
      end
    end
  end

  assign w_en[0] = w_run & w_tick & ~w_at_term;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit_updown u_dig (
      .Clock    (Clock),
      .Reset    (Reset),
      .en       (w_en[g]),
      .down     (r_mode),
      .load     (w_dload),
      .load_val (w_dval[g*BCD_W +: BCD_W]),
      .q        (w_digits[g*BCD_W +: BCD_W]),
      .d_next   (w_nxt[g*BCD_W +: BCD_W]),
      .co       (w_co[g])
    );

    if (g > 0) begin : g_chain
      assign w_en[g] = w_en[g-1] & w_co[g-1];
    end

    assign w_step[g*BCD_W +: BCD_W] = w_en[g] ?
      w_nxt[g*BCD_W +: BCD_W] :
      w_digits[g*BCD_W +: BCD_W];
  end

  // Top digit never overflows: the terminal value is hit first
  assign w_unused_co = w_co[NUM_DIGITS-1];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_time     <= '0;
      r_mode     <= 1'b0;
      r_pre      <= '0;
      r_expire   <= 1'b0;
      r_lerr     <= 1'b0;
      r_running  <= 1'b0;
      r_time_out <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_tload)
        r_time <= Timer_In_Value;
      if (w_mload)
        r_mode <= w_mval;
      if (w_pclr)
        r_pre <= '0;
      else if (w_run)
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      r_expire   <= w_expire;
      r_lerr     <= w_lerr;
      r_running  <= (w_nstate == RUN);
      r_time_out <= (w_nstate == DONE);
    end
  end

  assign Digits       = w_digits;
  assign Time_Out     = r_time_out;
  assign Expire_Pulse = r_expire;
  assign Running      = r_running;
  assign Load_Error   = r_lerr;

endmodule
